// File: rtl/ara_vcpop_seq_if.sv
// Handshake bundle for the vcpop.m / vfirst.m sequencer: command, operand beats and result.
// Signal names carry the direction as seen from the sequencer.
interface ara_vcpop_seq_if #(
  parameter int unsigned VLEN = 32'd4096
);
  localparam int unsigned CntW = $clog2(VLEN + 1);

  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic [CntW-1:0] cmd_vl_i;
  logic            cmd_vm_i;
  logic            operand_valid_i;
  logic            operand_ready_o;
  logic [63:0]     operand_i;
  logic [63:0]     mask_i;
  logic            result_valid_o;
  logic            result_ready_i;
  logic [CntW-1:0] result_cnt_o;
  logic [63:0]     result_first_o;

  modport master (
    output cmd_valid_i, cmd_vl_i, cmd_vm_i,
    output operand_valid_i, operand_i, mask_i,
    output result_ready_i,
    input  cmd_ready_o, operand_ready_o,
    input  result_valid_o, result_cnt_o, result_first_o
  );

  modport slave (
    input  cmd_valid_i, cmd_vl_i, cmd_vm_i,
    input  operand_valid_i, operand_i, mask_i,
    input  result_ready_i,
    output cmd_ready_o, operand_ready_o,
    output result_valid_o, result_cnt_o, result_first_o
  );
endinterface

// File: rtl/ara_vcpop_seq.sv
// Walks a multi-word mask operand 64 bits per beat, applying v0 and tail masks,
// accumulating the popcount and locating the first active set bit.
module ara_vcpop_seq #(
  parameter int unsigned VLEN = 32'd4096
) (
  input logic             clk_i,
  input logic             rst_ni,
  ara_vcpop_seq_if.slave  bus
);
  localparam int unsigned CntW  = $clog2(VLEN + 1);
  localparam int unsigned WIdxW = CntW - 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           r_state;
  logic             r_cmd_ready;
  logic             r_operand_ready;
  logic             r_result_valid;
  logic             r_vm;
  logic             r_found;
  logic [CntW-1:0]  r_rem;
  logic [WIdxW-1:0] r_word_idx;
  logic [CntW-1:0]  r_cnt;
  logic [63:0]      r_first;

  logic [CntW-1:0]  w_vl_sat;
  logic [63:0]      w_tail;
  logic [63:0]      w_eff;
  logic [6:0]       w_pop;
  logic [5:0]       w_lsb;
  logic             w_last;

  function automatic logic [6:0] popcnt64(input logic [63:0] v);
    logic [6:0] s;
    s = 7'd0;
    for (int i = 0; i < 64; i++) begin
      s = s + {6'd0, v[i]};
    end
    return s;
  endfunction

  function automatic logic [5:0] lsb_idx(input logic [63:0] v);
    logic [5:0] idx;
    idx = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) begin
        idx = 6'(i);
      end
    end
    return idx;
  endfunction

  // Beat datapath: saturate vl, build the tail mask and the effective word.
  always_comb begin
    w_vl_sat = bus.cmd_vl_i;
    if (bus.cmd_vl_i > CntW'(VLEN)) begin
      w_vl_sat = CntW'(VLEN);
    end else begin
      w_vl_sat = bus.cmd_vl_i;
    end
    w_tail = {64{1'b1}};
    if (r_rem >= CntW'(7'd64)) begin
      w_tail = {64{1'b1}};
    end else begin
      w_tail = (64'd1 << r_rem[5:0]) - 64'd1;
    end
    w_eff  = bus.operand_i & (r_vm ? {64{1'b1}} : bus.mask_i) & w_tail;
    w_pop  = popcnt64(w_eff);
    w_lsb  = lsb_idx(w_eff);
    w_last = (r_rem <= CntW'(7'd64));
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= S_IDLE;
      r_cmd_ready     <= 1'b0;
      r_operand_ready <= 1'b0;
      r_result_valid  <= 1'b0;
      r_vm            <= 1'b0;
      r_found         <= 1'b0;
      r_rem           <= {CntW{1'b0}};
      r_word_idx      <= {WIdxW{1'b0}};
      r_cnt           <= {CntW{1'b0}};
      r_first         <= {64{1'b1}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_cmd_ready && bus.cmd_valid_i) begin
            r_cmd_ready <= 1'b0;
            r_vm        <= bus.cmd_vm_i;
            r_rem       <= w_vl_sat;
            r_word_idx  <= {WIdxW{1'b0}};
            r_found     <= 1'b0;
            r_cnt       <= {CntW{1'b0}};
            r_first     <= {64{1'b1}};
            if (w_vl_sat == {CntW{1'b0}}) begin
              r_result_valid <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              r_operand_ready <= 1'b1;
              r_state         <= S_RUN;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_operand_ready && bus.operand_valid_i) begin
            r_cnt      <= r_cnt + CntW'(w_pop);
            r_word_idx <= r_word_idx + WIdxW'(1'b1);
            if (!r_found && (w_eff != 64'd0)) begin
              r_first <= 64'({r_word_idx, w_lsb});
              r_found <= 1'b1;
            end
            if (w_last) begin
              r_rem           <= {CntW{1'b0}};
              r_operand_ready <= 1'b0;
              r_result_valid  <= 1'b1;
              r_state         <= S_DONE;
            end else begin
              r_rem <= r_rem - CntW'(7'd64);
            end
          end
        end
        S_DONE: begin
          if (r_result_valid && bus.result_ready_i) begin
            r_result_valid <= 1'b0;
            r_cmd_ready    <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_state         <= S_IDLE;
          r_cmd_ready     <= 1'b0;
          r_operand_ready <= 1'b0;
          r_result_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o     = r_cmd_ready;
  assign bus.operand_ready_o = r_operand_ready;
  assign bus.result_valid_o  = r_result_valid;
  assign bus.result_cnt_o    = r_cnt;
  assign bus.result_first_o  = r_first;
endmodule

// File: tb/tb_ara_vcpop_seq.sv
// Bench for ara_vcpop_seq: directed vector table, mid-run reset sequence and
// randomized commands checked against a bit-level reference model.
module tb_ara_vcpop_seq;
  localparam int unsigned VLEN = 32'd4096;
  localparam int unsigned CntW = $clog2(VLEN + 1);
  localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [CntW-1:0] vl;
    logic            vm;
    logic [63:0]     op0;
    logic [63:0]     op1;
    logic [63:0]     mk0;
    logic [63:0]     mk1;
    logic [CntW-1:0] cnt;
    logic [63:0]     first;
    int              beats;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   hs_beats = 0;
  logic [63:0] op_w [64];
  logic [63:0] mk_w [64];
  vec_t vt [7];

  always #5 clk = ~clk;

  ara_vcpop_seq_if #(.VLEN(VLEN)) bus ();

  ara_vcpop_seq #(.VLEN(VLEN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always @(posedge clk) begin
    if (rst_n && bus.operand_valid_i && bus.operand_ready_o) hs_beats <= hs_beats + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  // Reference: walk every active element bit individually.
  task automatic model(input int vl, input logic vm, output int cnt, output logic [63:0] first,
                       output int beats);
    int  n;
    bit  found;
    n     = (vl > int'(VLEN)) ? int'(VLEN) : vl;
    cnt   = 0;
    first = NONE;
    found = 1'b0;
    for (int b = 0; b < n; b++) begin
      if (op_w[b / 64][b % 64] && (vm || mk_w[b / 64][b % 64])) begin
        cnt++;
        if (!found) begin
          first = 64'(b);
          found = 1'b1;
        end
      end
    end
    beats = (n + 63) / 64;
  endtask

  task automatic run_cmd(input string name, input logic [CntW-1:0] vl, input logic vm,
                         input bit gaps, input logic [CntW-1:0] exp_cnt,
                         input logic [63:0] exp_first, input int exp_beats);
    int n;
    int idx;
    int start;
    int k;
    bit ok;
    @(negedge clk);
    bus.cmd_vl_i    = vl;
    bus.cmd_vm_i    = vm;
    bus.cmd_valid_i = 1'b1;
    n = 0;
    while (bus.cmd_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      timeout({name, " cmd"});
      bus.cmd_valid_i = 1'b0;
      return;
    end
    start = hs_beats;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    idx = 0;
    n   = 0;
    while (idx < exp_beats && n < exp_beats * 20 + 50) begin
      bus.operand_i       = op_w[idx];
      bus.mask_i          = mk_w[idx];
      bus.operand_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      ok = bus.operand_valid_i && bus.operand_ready_o;
      @(posedge clk);
      @(negedge clk);
      n++;
      if (ok) idx++;
    end
    bus.operand_valid_i = 1'b0;
    if (idx < exp_beats) timeout({name, " beats"});
    check({name, " latency"}, 64'(bus.result_valid_o), 64'd1);
    check({name, " opready_low"}, 64'(bus.operand_ready_o), 64'd0);
    n = 0;
    while (bus.result_valid_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      timeout({name, " result"});
      return;
    end
    k = gaps ? $urandom_range(1, 4) : 0;
    for (int c = 0; c < k; c++) begin
      @(negedge clk);
      check({name, " hold_cnt"}, 64'(bus.result_cnt_o), 64'(exp_cnt));
      check({name, " hold_first"}, bus.result_first_o, exp_first);
    end
    bus.result_ready_i = 1'b1;
    check({name, " cnt"}, 64'(bus.result_cnt_o), 64'(exp_cnt));
    check({name, " first"}, bus.result_first_o, exp_first);
    check({name, " nbeats"}, 64'(hs_beats - start), 64'(exp_beats));
    @(posedge clk);
    @(negedge clk);
    bus.result_ready_i = 1'b0;
    check({name, " valid_drop"}, 64'(bus.result_valid_o), 64'd0);
    check({name, " back_idle"}, 64'(bus.cmd_ready_o), 64'd1);
  endtask

  initial begin
    int          rcnt;
    int          rbeats;
    logic [63:0] rfirst;
    int          rvl;
    logic        rvm;

    bus.cmd_valid_i     = 1'b0;
    bus.cmd_vl_i        = {CntW{1'b0}};
    bus.cmd_vm_i        = 1'b1;
    bus.operand_valid_i = 1'b0;
    bus.operand_i       = 64'd0;
    bus.mask_i          = 64'd0;
    bus.result_ready_i  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      op_w[i] = 64'd0;
      mk_w[i] = 64'd0;
    end

    vt[0] = '{13'd64,  1'b1, 64'hF0, 64'h0, 64'h0, 64'h0, 13'd4, 64'd4, 32'd1};
    vt[1] = '{13'd70,  1'b1, 64'h0, 64'hFF, 64'h0, 64'h0, 13'd6, 64'd64, 32'd2};
    vt[2] = '{13'd128, 1'b0, NONE, NONE, 64'h1, 64'h3, 13'd3, 64'd0, 32'd2};
    vt[3] = '{13'd0,   1'b1, NONE, NONE, 64'h0, 64'h0, 13'd0, NONE, 32'd0};
    vt[4] = '{13'd1,   1'b1, 64'h2, 64'h0, 64'h0, 64'h0, 13'd0, NONE, 32'd1};
    vt[5] = '{13'd65,  1'b0, 64'hFFFF, 64'h1, 64'h0, 64'h3, 13'd1, 64'd64, 32'd2};
    vt[6] = '{13'd128, 1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h0, 64'h0, 13'd2, 64'd63, 32'd2};

    #12;
    check("rst cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
    check("rst op_ready", 64'(bus.operand_ready_o), 64'd0);
    check("rst res_valid", 64'(bus.result_valid_o), 64'd0);
    check("rst cnt", 64'(bus.result_cnt_o), 64'd0);
    check("rst first", bus.result_first_o, NONE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel cmd_ready", 64'(bus.cmd_ready_o), 64'd1);

    for (int i = 0; i < 7; i++) begin
      op_w[0] = vt[i].op0;
      op_w[1] = vt[i].op1;
      mk_w[0] = vt[i].mk0;
      mk_w[1] = vt[i].mk1;
      run_cmd($sformatf("vec%0d", i), vt[i].vl, vt[i].vm, 1'b0, vt[i].cnt, vt[i].first,
              vt[i].beats);
    end

    // Full-length all-ones operand with stalls and backpressure.
    for (int i = 0; i < 64; i++) op_w[i] = NONE;
    run_cmd("full", 13'd4096, 1'b1, 1'b1, 13'd4096, 64'd0, 64);

    // Reset in the middle of an accumulation.
    @(negedge clk);
    bus.cmd_vl_i    = 13'd4096;
    bus.cmd_vm_i    = 1'b1;
    bus.cmd_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i     = 1'b0;
    bus.operand_i       = NONE;
    bus.operand_valid_i = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.operand_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
    check("midrst op_ready", 64'(bus.operand_ready_o), 64'd0);
    check("midrst res_valid", 64'(bus.result_valid_o), 64'd0);
    check("midrst cnt", 64'(bus.result_cnt_o), 64'd0);
    check("midrst first", bus.result_first_o, NONE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst rel", 64'(bus.cmd_ready_o), 64'd1);
    op_w[0] = 64'h1;
    run_cmd("post_rst", 13'd64, 1'b1, 1'b0, 13'd1, 64'd0, 1);

    for (int t = 0; t < 20; t++) begin
      rvl = (t == 0) ? 8191 : (t == 1) ? 4096 : int'($urandom_range(0, 4200));
      rvm = 1'($urandom_range(0, 1));
      for (int i = 0; i < 64; i++) begin
        op_w[i] = {$urandom, $urandom};
        mk_w[i] = {$urandom, $urandom};
        if ((t % 3) == 2) op_w[i] = op_w[i] & {$urandom, $urandom} & {$urandom, $urandom}
                                          & {$urandom, $urandom};
        if ((t % 5) == 4 && i < 20) op_w[i] = 64'd0;
      end
      model(rvl, rvm, rcnt, rfirst, rbeats);
      run_cmd($sformatf("rand%0d", t), CntW'(rvl), rvm, 1'b1, CntW'(rcnt), rfirst, rbeats);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
